// File: rtl/uart_tx_sequencer_if.sv
// Character handshake between a producer and the UART transmit frame sequencer.
interface uart_tx_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: start, 7/8 data bits LSB first, optional parity, one stop bit.
// Each bit is held for CLK_DIV clocks; the frame format is latched when a character is accepted.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | line high, tx_ready high, waiting for tx_valid
// S_START  | start bit (line low)
// S_DATA   | data bit bit_cnt of the latched character
// S_PARITY | parity bit (only when parity was enabled at acceptance)
// S_STOP   | stop bit (line high), returns to idle on last divider cycle
module uart_tx_sequencer #(
    parameter int CLK_DIV = 16
) (
    input  logic                clk,
    input  logic                rstb,
    uart_tx_sequencer_if.slave  tx_if,
    input  logic                bit8,
    input  logic                parity_en,
    input  logic                odd_n_even,
    output logic                tx_out,
    output logic                busy,
    output logic [3:0]          frame_bits
);

    localparam int              DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       data_q;
    logic             bit8_q;
    logic             par_en_q;
    logic             odd_q;
    logic             div_tick;
    logic             last_bit;
    logic             parity_bit;

    assign div_tick   = (div_cnt == DIV_LAST);
    assign last_bit   = (bit_cnt == (bit8_q ? 3'd7 : 3'd6));
    // Bit 7 is masked out so 7-bit frames never see a stale MSB in the parity.
    assign parity_bit = (^(data_q & {bit8_q, 7'h7F})) ^ odd_q;

    assign tx_if.tx_ready = (state == S_IDLE);
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_out     = 1'b1;
        case (state)
            S_IDLE: begin
                if (tx_if.tx_valid) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                tx_out = 1'b0;
                if (div_tick) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                tx_out = data_q[bit_cnt];
                if (div_tick && last_bit) begin
                    state_next = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                tx_out = parity_bit;
                if (div_tick) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (div_tick) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            bit8_q     <= 1'b0;
            par_en_q   <= 1'b0;
            odd_q      <= 1'b0;
            frame_bits <= '0;
        end else if (state == S_IDLE) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            if (tx_if.tx_valid) begin
                data_q     <= tx_if.tx_data;
                bit8_q     <= bit8;
                par_en_q   <= parity_en;
                odd_q      <= odd_n_even;
                frame_bits <= 4'd9 + {3'b000, bit8} + {3'b000, parity_en};
            end
        end else begin
            div_cnt <= div_tick ? '0 : div_cnt + DIV_W'(1);
            if (state == S_DATA && div_tick) begin
                bit_cnt <= last_bit ? 3'd0 : bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: two instances (CLK_DIV 4 and 2), each with its own driver,
// frame scoreboard and line monitor comparing against a bit-level frame model.
module tb_uart_tx_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] data;
        bit         b8;
        bit         pe;
        bit         odd;
        int         acc;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        bit         b8;
        bit         pe;
        bit         odd;
        bit         hold;
        bit         flip;
        bit         rst;
        int         gap;
    } stim_t;

    task automatic check(int d, string name, int act, int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL div%0d %s: got %0d expected %0d (t=%0t)", d, name, act, exp, $time);
        end
    endtask

    function automatic int nbits(frame_t f);
        return 9 + int'(f.b8) + int'(f.pe);
    endfunction

    // Line level of serial bit k of the frame, built from the framing rules.
    function automatic logic line_bit(frame_t f, int k);
        int         nd;
        int         ones;
        logic [7:0] m;
        nd   = f.b8 ? 8 : 7;
        m    = f.b8 ? 8'hFF : 8'h7F;
        ones = $countones(f.data & m);
        if (k == 0) return 1'b0;
        if (k <= nd) return f.data[k-1];
        if (f.pe && k == nd + 1) return ((ones % 2) == 1) ^ f.odd;
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int D = (g == 0) ? 4 : 2;

        logic       rstb;
        logic       bit8;
        logic       parity_en;
        logic       odd_n_even;
        logic       tx_out;
        logic       busy;
        logic [3:0] frame_bits;
        bit         done     = 1'b0;
        bit         in_frame = 1'b0;
        int         cyc      = 0;
        frame_t     q[$];

        uart_tx_sequencer_if bus();

        uart_tx_sequencer #(.CLK_DIV(D)) dut (
            .clk        (clk),
            .rstb       (rstb),
            .tx_if      (bus),
            .bit8       (bit8),
            .parity_en  (parity_en),
            .odd_n_even (odd_n_even),
            .tx_out     (tx_out),
            .busy       (busy),
            .frame_bits (frame_bits)
        );

        always @(posedge clk) cyc <= cyc + 1;

        initial begin : drv
            stim_t st[$];
            stim_t s;
            frame_t f;
            int w;
            bit held;
            int prev_acc;
            int prev_n;

            rstb          = 1'b0;
            bus.tx_valid  = 1'b0;
            bus.tx_data   = 8'h00;
            bit8          = 1'b0;
            parity_en     = 1'b0;
            odd_n_even    = 1'b0;
            held          = 1'b0;
            prev_acc      = 0;
            prev_n        = 0;
            @(negedge clk);
            check(D, "reset_state", int'({tx_out, bus.tx_ready, busy, frame_bits}), int'(7'b1100000));
            rstb = 1'b1;

            //            data   b8 pe od hold flip rst gap
            st.push_back('{8'h4A, 1, 0, 0, 0, 0, 0, 2});
            st.push_back('{8'h4A, 1, 1, 0, 0, 0, 0, 1});
            st.push_back('{8'h4A, 1, 1, 1, 0, 0, 0, 0});
            st.push_back('{8'hCA, 0, 1, 1, 0, 0, 0, 3});
            st.push_back('{8'h55, 1, 0, 0, 1, 1, 0, 1});
            st.push_back('{8'hAA, 0, 0, 0, 0, 0, 0, 0});
            st.push_back('{8'h35, 1, 0, 0, 0, 0, 1, 2});
            st.push_back('{8'h0F, 1, 0, 0, 0, 0, 0, 1});
            for (int i = 0; i < 16; i++) begin
                s.data = 8'($urandom);
                s.b8   = 1'($urandom);
                s.pe   = 1'($urandom);
                s.odd  = 1'($urandom);
                s.hold = 1'($urandom);
                s.flip = 1'($urandom);
                s.rst  = 1'b0;
                s.gap  = int'($urandom_range(0, 3));
                st.push_back(s);
            end
            st[st.size()-1].hold = 1'b0;

            foreach (st[i]) begin
                s = st[i];
                @(negedge clk);
                if (!held) repeat (s.gap) @(negedge clk);
                bus.tx_data  = s.data;
                bit8         = s.b8;
                parity_en    = s.pe;
                odd_n_even   = s.odd;
                bus.tx_valid = 1'b1;
                w = 0;
                while (!bus.tx_ready && w < 300) begin
                    @(negedge clk);
                    w++;
                end
                if (w >= 300) begin
                    check(D, "accept_timeout", w, 0);
                    break;
                end
                f = '{s.data, s.b8, s.pe, s.odd, cyc + 1};
                q.push_back(f);
                if (held) check(D, "b2b_spacing", f.acc - prev_acc, prev_n * D + 1);
                prev_acc = f.acc;
                prev_n   = nbits(f);
                @(posedge clk);
                #1;
                // Scramble everything after acceptance; the frame in flight must not notice.
                bus.tx_data = 8'($urandom);
                parity_en   = 1'($urandom);
                odd_n_even  = 1'($urandom);
                if (s.flip) bit8 = ~bit8;
                bus.tx_valid = s.hold && !s.rst;
                held         = s.hold && !s.rst;
                if (s.rst) begin
                    while (cyc < f.acc + 4 * D + 1) @(negedge clk);
                    check(D, "pre_reset_line", int'(tx_out), 0);
                    #1 rstb = 1'b0;
                    #1 check(D, "reset_mid_frame", int'({tx_out, bus.tx_ready, busy, frame_bits}),
                             int'(7'b1100000));
                    repeat (2) @(negedge clk);
                    rstb = 1'b1;
                end
            end

            w = 0;
            while ((q.size() != 0 || in_frame) && w < 1000) begin
                @(negedge clk);
                w++;
            end
            check(D, "drain", int'(w < 1000), 1);
            done = 1'b1;
        end

        initial begin : mon
            frame_t f;
            int n;
            int errs;
            bit aborted;
            forever begin
                @(negedge clk);
                if (rstb === 1'b1 && tx_out === 1'b0) begin
                    if (q.size() == 0) begin
                        check(D, "unexpected_start", int'(q.size()), 1);
                    end else begin
                        f        = q.pop_front();
                        in_frame = 1'b1;
                        n        = nbits(f);
                        check(D, "start_latency", cyc, f.acc);
                        check(D, "frame_bits", int'(frame_bits), n);
                        errs    = 0;
                        aborted = 1'b0;
                        for (int j = 0; j < n * D; j++) begin
                            if (j > 0) @(negedge clk);
                            if (!rstb) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (tx_out !== line_bit(f, j / D) || bus.tx_ready !== 1'b0 || busy !== 1'b1)
                                errs++;
                        end
                        if (aborted) begin
                            q.delete();
                        end else begin
                            check(D, "line_bits", errs, 0);
                            @(negedge clk);
                            if (rstb)
                                check(D, "idle_after_stop", int'({bus.tx_ready, busy, tx_out}),
                                      int'(3'b101));
                        end
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : fin
        int t;
        t = 0;
        while (!(inst[0].done && inst[1].done) && t < 80000) begin
            @(posedge clk);
            t++;
        end
        check(0, "finished", int'(inst[0].done && inst[1].done), 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
